// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, inserts WAIT_CYCLES
// wait states, then presents a single held response until the core takes it.
module dmem_responder #(
  parameter int ADDR_W      = 19,
  parameter int DATA_W      = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [3:0]        req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                hold_we_q, hold_we_d;
  logic [ADDR_W-1:0]   hold_addr_q, hold_addr_d;
  logic [DATA_W-1:0]   hold_wdata_q, hold_wdata_d;
  logic [3:0]          hold_be_q, hold_be_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  logic [DATA_W-1:0]   mem [2**DEPTH_LOG2];

  logic                op_we;
  logic [ADDR_W-1:0]   op_addr;
  logic [DATA_W-1:0]   op_wdata;
  logic [3:0]          op_be;
  logic [DEPTH_LOG2-1:0] op_idx;
  logic                op_err;
  logic                enter_resp;
  logic                mem_we;

  // With zero wait states RESP is entered on the accept edge itself, so the
  // operation must come straight from the request port rather than the holding regs.
  always_comb begin
    if (state_q == IDLE) begin
      op_we    = req_we;
      op_addr  = req_addr;
      op_wdata = req_wdata;
      op_be    = req_be;
    end else begin
      op_we    = hold_we_q;
      op_addr  = hold_addr_q;
      op_wdata = hold_wdata_q;
      op_be    = hold_be_q;
    end
    op_idx = op_addr[DEPTH_LOG2+1:2];
    op_err = (op_addr[1:0] != 2'b00) || ((op_addr >> (DEPTH_LOG2 + 2)) != '0);
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hold_we_d    = hold_we_q;
    hold_addr_d  = hold_addr_q;
    hold_wdata_d = hold_wdata_q;
    hold_be_d    = hold_be_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    enter_resp   = 1'b0;
    mem_we       = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          hold_we_d    = req_we;
          hold_addr_d  = req_addr;
          hold_wdata_d = req_wdata;
          hold_be_d    = req_be;
          if (WAIT_CYCLES == 0) begin
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) enter_resp = 1'b1;
        else               cnt_d = cnt_q - 4'd1;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (enter_resp) begin
      state_d     = RESP;
      rsp_valid_d = 1'b1;
      rsp_err_d   = op_err;
      rsp_rdata_d = (op_we || op_err) ? '0 : mem[op_idx];
      mem_we      = op_we && !op_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_ff @(posedge clk) begin
    hold_we_q    <= hold_we_d;
    hold_addr_q  <= hold_addr_d;
    hold_wdata_q <= hold_wdata_d;
    hold_be_q    <= hold_be_d;
  end

  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (op_be[b]) mem[op_idx][8*b +: 8] <= op_wdata[8*b +: 8];
      end
    end
  end

  assign req_ready = (state_q == IDLE) && !rst;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
